xor_stim_checker: RTL and testbench
===================================

# xor_stim_checker

Synthesizable stimulus-and-check stage for the two-input XOR gate. It sweeps the gate's `a`/`b` inputs through all four combinations, holds each for a programmable number of cycles, and samples the gate's output against the expected XOR value. It then reports an error count and a pass/fail verdict. It sits directly upstream of the gate, which it feeds, and directly downstream of it, consuming the gate's output. The gate can then be self-checked in simulation or on a board without a hand-written initial block.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: cycles each vector is held; legal range is 1 or more.
- `REPEAT`, default 1: number of full 4-vector sweeps per run; legal range is 1 or more.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `start`  input  1: starts a run when the block is idle or done.
- `a`  output  1: gate input A (registered).
- `b`  output  1: gate input B (registered).
- `dut_out`  input  1: gate output (combinational from `a`/`b`).
- `busy`  output  1: high while a run is in progress.
- `done`  output  1: high from run end until the next `start` or `rst`.
- `pass`  output  1: equals `done && (err_cnt == 0)`.
- `err_cnt`  output  ERR_W: number of mismatches in the current or last run; saturates.
- `vec_idx`  output  2: index of the vector being driven; `a = vec_idx[1]`, `b = vec_idx[0]`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `a`, `b`, `vec_idx`, `busy`, `done` are 0.
  - `err_cnt` is cleared on entry from `rst` only.
  - `start` moves the FSM to RUN, clears `err_cnt`, and sets `vec_idx`=0, hold counter=0, sweep counter=0.
- RUN:
  - The vector order is 00, 01, 10, 11, repeated `REPEAT` times.
  - The hold counter counts 0..HOLD_CYCLES-1.
  - On the last hold cycle, `dut_out` is compared with `a ^ b`. A mismatch increments `err_cnt`, saturating at 2^ERR_W-1.
  - The vector then advances: `vec_idx` wraps 3→0 and increments the sweep counter.
  - After the compare of vector 3 in sweep REPEAT-1, the FSM goes to DONE.
- DONE:
  - `done`=1.
  - `a`/`b` return to 0.
  - `err_cnt` is frozen.
  - `start` re-enters RUN exactly as from IDLE.
- `start` is ignored while in RUN; it is not queued.
- `rst` has priority over everything. Asserted mid-run, it aborts the run and the block returns to IDLE at the next edge with all outputs 0.
- `pass` is derived combinationally from registered `done` and `err_cnt`.

## Timing
- Reset values: `a`=0, `b`=0, `vec_idx`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0.
- `start` sampled high at edge k: `busy`=1 and vector 00 are driven from edge k (visible in cycle k+1).
- Each vector is visible for exactly HOLD_CYCLES cycles.
- `dut_out` is sampled at the closing edge of the vector's last cycle, so the gate has at least one full cycle to settle.
- A run occupies 4·HOLD_CYCLES·REPEAT cycles of `busy`=1.
- `done` rises on the same edge that `busy` falls and that the final compare updates `err_cnt`.
- With `start` and the final compare at the same edge in RUN, `start` is ignored.
- With `start` in DONE, `done` falls and `busy` rises on the same edge.
- With HOLD_CYCLES=1, the vector changes every cycle and a compare happens every cycle; there are no idle gaps between vectors.

## Structure
- Shared package `xor_tb_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`).
  - Constant `NUM_VEC`=4.
  - Vector index type (2 bits).
- One sub-module, `hold_timer`:
  - Parameterized by HOLD_CYCLES.
  - Inputs: `clk`, `rst`, `clear`, `en`.
  - Output: `last`, a one-cycle flag on the final hold cycle.
- The top level holds the FSM, the vector/sweep counters and the saturating error counter.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0; `start` held low leaves `busy`=0.
- Correct XOR, HOLD_CYCLES=2, REPEAT=1, `start` pulse → `a`/`b` = 00,00,01,01,10,10,11,11; `busy` high for 8 cycles; then `done`=1, `pass`=1, `err_cnt`=0.
- Faulty DUT with `dut_out` stuck at 0, REPEAT=2 → `err_cnt`=4 (vectors 01 and 10 in each sweep), `pass`=0, `done`=1.
- Faulty DUT (`dut_out` stuck at 1), ERR_W=2, REPEAT=4 → 8 mismatches saturate `err_cnt` at 3.
- `start` pulsed mid-run → ignored, and run length is unchanged.
- `start` in DONE → new run begins with `err_cnt` cleared.
- `rst` asserted during vector 10 → next cycle all outputs 0, state IDLE.
- A subsequent `start` → full correct run from vector 00.

Source files
------------

// File: rtl/xor_tb_pkg.sv
// rtl/xor_tb_pkg.sv - shared types and constants for the XOR gate stimulus/check stage
package xor_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int NUM_VEC = 4;

    typedef logic [1:0] vec_t;

endpackage

// File: rtl/xor_stim_checker_hold_timer.sv
// rtl/xor_stim_checker_hold_timer.sv - counts hold cycles per vector and flags the last one
module hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign last = en && (cnt == CW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xor_stim_checker.sv
// rtl/xor_stim_checker.sv - sweeps a/b through all four vectors and checks the XOR gate output
module xor_stim_checker
    import xor_tb_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int REPEAT      = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int SW_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [SW_W-1:0] sweep;
    logic            last;
    logic            final_cmp;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state != ST_RUN),
        .en   (state == ST_RUN),
        .last (last)
    );

    assign final_cmp = last && (vec_idx == vec_t'(NUM_VEC - 1)) && (sweep == SW_W'(REPEAT - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
            ST_RUN:           if (final_cmp) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // vec_idx wraps to 0 on the final compare, so a/b return to 0 in DONE for free
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx <= '0;
            sweep   <= '0;
            err_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_idx <= '0;
                        sweep   <= '0;
                        err_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        if ((dut_out != (a ^ b)) && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        vec_idx <= vec_idx + 1'b1;
                        if (vec_idx == vec_t'(NUM_VEC - 1)) begin
                            sweep <= sweep + 1'b1;
                        end
                    end
                end
                default: begin
                    vec_idx <= '0;
                    sweep   <= '0;
                end
            endcase
        end
    end

    assign a    = vec_idx[1];
    assign b    = vec_idx[0];
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_xor_stim_checker.sv
// tb/tb_xor_stim_checker.sv - scoreboard bench for xor_stim_checker with correct and faulty gates
module tb_xor_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic sel;
    int   fault;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    // instance a: HOLD=2 REPEAT=2 ERR_W=8; instance b: HOLD=1 REPEAT=4 ERR_W=2
    logic       a_a, b_a, dut_out_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [1:0] vec_a;
    logic       a_b, b_b, dut_out_b, busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [1:0] vec_b;

    assign dut_out_a = (fault == 0) ? (a_a ^ b_a) : (fault == 2);
    assign dut_out_b = (fault == 0) ? (a_b ^ b_b) : (fault == 2);

    xor_stim_checker #(.HOLD_CYCLES(2), .REPEAT(2), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .a(a_a), .b(b_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .vec_idx(vec_a)
    );

    xor_stim_checker #(.HOLD_CYCLES(1), .REPEAT(4), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .a(a_b), .b(b_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .vec_idx(vec_b)
    );

    logic       a_o, b_o, busy_o, done_o, pass_o;
    logic [7:0] err_o;
    logic [1:0] vec_o;
    assign a_o    = sel ? a_b    : a_a;
    assign b_o    = sel ? b_b    : b_a;
    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign pass_o = sel ? pass_b : pass_a;
    assign err_o  = sel ? {6'b0, err_b} : err_a;
    assign vec_o  = sel ? vec_b  : vec_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_pass"}, 32'(pass_o), 32'd0);
        check({tag, "_err"},  32'(err_o),  32'd0);
        check({tag, "_ab"},   32'({a_o, b_o}), 32'd0);
        check({tag, "_vec"},  32'(vec_o),  32'd0);
    endtask

    // pulse_at: -1 none, -2 on the final-compare edge, n>=0 after n busy cycles
    task automatic run(input string tag, input int pulse_at);
        int hold  = sel ? 1 : 2;
        int rep   = sel ? 4 : 2;
        int emax  = sel ? 3 : 255;
        int raw   = (fault == 0) ? 0 : 2 * rep;
        int exp_err = (raw > emax) ? emax : raw;
        int n = 0;
        logic [1:0] v;
        exp_q.delete();
        for (int s = 0; s < rep; s++)
            for (int k = 0; k < 4; k++)
                for (int h = 0; h < hold; h++)
                    exp_q.push_back(2'(k));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_start_done"}, 32'(done_o), 32'd0);
        check({tag, "_start_err"},  32'(err_o),  32'd0);
        while (busy_o && n < 200) begin
            v = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
            check({tag, "_vec"}, 32'({vec_o, a_o, b_o}), 32'({v, v}));
            start = (n == pulse_at) || (pulse_at == -2 && exp_q.size() == 0);
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_busy_len"}, 32'(n), 32'(4 * hold * rep));
        check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check({tag, "_pass"}, 32'(pass_o), 32'(exp_err == 0));
        check({tag, "_ab_done"}, 32'({a_o, b_o}), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_hold"}, 32'({busy_o, done_o}), 32'b01);
    endtask

    task automatic abort_run(input string tag);
        int n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (vec_o != 2'd2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_reached_10"}, 32'({a_o, b_o}), 32'b10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_zero(tag);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        fault = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle_zero("reset_a");
        sel = 1'b1; #1;
        idle_zero("reset_b");
        sel = 1'b0; #1;

        fault = 0; run("good_a", -1);
        fault = 1; run("stuck0_a", 3);
        fault = 0; run("restart_a", -1);
        sel = 1'b1; #1;
        fault = 2; run("stuck1_sat_b", -2);
        fault = 0; run("good_h1_b", -1);
        sel = 1'b0; #1;
        abort_run("abort_a");
        run("after_abort_a", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
